// File: rtl/dac_write_arbiter.sv
// Shares one DAC8531 serializer between the GPS calibration loop and a host port.
// Define DAC_SLEW_LIMIT_EN to clamp each granted code to LAST_CODE +/- MAX_STEP.
module dac_write_arbiter #(
  parameter logic [15:0] INIT_CODE      = 16'd31200,
  parameter int          TR_CYCLES      = 2,
  parameter int          SETTLE_CYCLES  = 1000,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          MAX_STEP       = 2048
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        CAL_REQ,
  input  logic [15:0] CAL_DATA,
  output logic        CAL_ACK,
  input  logic        HOST_REQ,
  input  logic [15:0] HOST_DATA,
  output logic        HOST_ACK,
  input  logic        HOST_LOCK,
  output logic        DA_TR,
  output logic [15:0] DA_DATA,
  input  logic        DA_OVER,
  output logic        BUSY,
  output logic        GRANT_HOST,
  output logic [15:0] LAST_CODE,
  output logic        TIMEOUT_ERR
);

  localparam int MAX_A = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                         TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int MAX_C = (MAX_A > TR_CYCLES) ? MAX_A : TR_CYCLES;
  localparam int CW    = ($clog2(MAX_C + 1) > 13) ?
                         $clog2(MAX_C + 1) : 13;

  localparam logic [CW-1:0] TR_LAST = CW'(TR_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST =
    CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

`ifdef DAC_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   last_q, last_d;
  logic          gh_q, gh_d;
  logic          tr_q, tr_d;
  logic          err_q, err_d;
  logic          cack_q, cack_d;
  logic          hack_q, hack_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        cal_ok;
  logic        any_req;
  logic        pick_host;
  logic        to_hit;
  logic [15:0] sel_code;
  logic [15:0] grant_code;
  int          lo_v, hi_v, clamp_v;

  // Tie goes to whoever did not own the last grant.
  assign cal_ok    = CAL_REQ & ~HOST_LOCK;
  assign any_req   = HOST_REQ | cal_ok;
  assign pick_host = HOST_REQ & (~cal_ok | ~gh_q);
  assign sel_code  = pick_host ? HOST_DATA : CAL_DATA;
  assign to_hit    = (cnt_q == TO_LAST);

  always_comb begin
    lo_v = int'(last_q) - MAX_STEP;
    hi_v = int'(last_q) + MAX_STEP;
    if (lo_v < 0)     lo_v = 0;
    if (hi_v > 65535) hi_v = 65535;
    clamp_v = int'(sel_code);
    if (clamp_v < lo_v)      clamp_v = lo_v;
    else if (clamp_v > hi_v) clamp_v = hi_v;
    grant_code = SLEW_EN ? 16'(clamp_v) : sel_code;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    gh_d    = gh_q;
    tr_d    = tr_q;
    err_d   = err_q;
    cack_d  = 1'b0;
    hack_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          cack_d  = ~pick_host;
          hack_d  = pick_host;
          gh_d    = pick_host;
          data_d  = grant_code;
          cnt_d   = '0;
          state_d = S_WAIT_RDY;
        end
      end
      // Reached only out of reset: the power-up write, never acked.
      S_LOAD: begin
        data_d  = INIT_CODE;
        cnt_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (DA_OVER) begin
          tr_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_STROBE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          tr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == TR_LAST) begin
          tr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (!DA_OVER) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          tr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (DA_OVER) begin
          last_d  = data_q;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          tr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        tr_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_10M) begin
    if (!RESET_N) begin
      state_q <= S_LOAD;
      data_q  <= INIT_CODE;
      last_q  <= INIT_CODE;
      gh_q    <= 1'b0;
      tr_q    <= 1'b0;
      err_q   <= 1'b0;
      cack_q  <= 1'b0;
      hack_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      gh_q    <= gh_d;
      tr_q    <= tr_d;
      err_q   <= err_d;
      cack_q  <= cack_d;
      hack_q  <= hack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CAL_ACK     = cack_q;
  assign HOST_ACK    = hack_q;
  assign DA_TR       = tr_q;
  assign DA_DATA     = data_q;
  assign BUSY        = (state_q != S_IDLE);
  assign GRANT_HOST  = gh_q;
  assign LAST_CODE   = last_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter with a DAC8531 serializer model
// (busy 20 clocks after each TR, optionally stuck idle).
module tb_dac_write_arbiter;

  logic        CLOCK_10M = 1'b0;
  logic        RESET_N;
  logic        CAL_REQ;
  logic [15:0] CAL_DATA;
  logic        CAL_ACK;
  logic        HOST_REQ;
  logic [15:0] HOST_DATA;
  logic        HOST_ACK;
  logic        HOST_LOCK;
  logic        DA_TR;
  logic [15:0] DA_DATA;
  logic        DA_OVER;
  logic        BUSY;
  logic        GRANT_HOST;
  logic [15:0] LAST_CODE;
  logic        TIMEOUT_ERR;

  dac_write_arbiter dut (
    .CLOCK_10M  (CLOCK_10M),
    .RESET_N    (RESET_N),
    .CAL_REQ    (CAL_REQ),
    .CAL_DATA   (CAL_DATA),
    .CAL_ACK    (CAL_ACK),
    .HOST_REQ   (HOST_REQ),
    .HOST_DATA  (HOST_DATA),
    .HOST_ACK   (HOST_ACK),
    .HOST_LOCK  (HOST_LOCK),
    .DA_TR      (DA_TR),
    .DA_DATA    (DA_DATA),
    .DA_OVER    (DA_OVER),
    .BUSY       (BUSY),
    .GRANT_HOST (GRANT_HOST),
    .LAST_CODE  (LAST_CODE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Serializer model
  bit       stuck = 1'b0;
  int       busy_cnt = 0;
  logic     tr_d1 = 1'b0;
  assign DA_OVER = stuck ? 1'b1 : (busy_cnt == 0);

  always @(posedge CLOCK_10M) begin
    if (DA_TR && !tr_d1) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    tr_d1 <= DA_TR;
  end

  // Output monitor
  int cyc = 0;
  int n_tr, n_cal, n_host, tr_len, last_len, fall_cyc;
  bit have_fall, len_bad, gap_bad, both_ack, tr_prev;

  always @(posedge CLOCK_10M) cyc <= cyc + 1;

  always @(negedge CLOCK_10M) begin
    if (CAL_ACK && HOST_ACK) both_ack = 1'b1;
    if (CAL_ACK === 1'b1) n_cal++;
    if (HOST_ACK === 1'b1) n_host++;
    if (DA_TR === 1'b1) tr_len++;
    if (DA_TR === 1'b1 && !tr_prev) begin
      n_tr++;
      if (have_fall && (cyc - fall_cyc) < 1000) gap_bad = 1'b1;
    end
    if (DA_TR !== 1'b1 && tr_prev) begin
      last_len = tr_len;
      if (tr_len != 2) len_bad = 1'b1;
      tr_len    = 0;
      fall_cyc  = cyc;
      have_fall = 1'b1;
    end
    tr_prev = (DA_TR === 1'b1);
  end

  task automatic clr_mon();
    n_tr = 0; n_cal = 0; n_host = 0; last_len = 0;
    have_fall = 1'b0; len_bad = 1'b0; gap_bad = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLOCK_10M);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    tick();
    while (BUSY !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", BUSY, 0);
  endtask

  task automatic do_req(input bit host, input logic [15:0] d,
                        input logic [15:0] exp);
    int n = 0;
    if (host) begin
      HOST_DATA = d;
      HOST_REQ  = 1'b1;
    end else begin
      CAL_DATA = d;
      CAL_REQ  = 1'b1;
    end
    while (!(host ? HOST_ACK : CAL_ACK) && n < 3000) begin
      tick();
      n++;
    end
    if (host) begin
      chk("host_ack", HOST_ACK, 1);
      chk("host_ack_excl", CAL_ACK, 0);
      HOST_REQ = 1'b0;
    end else begin
      chk("cal_ack", CAL_ACK, 1);
      chk("cal_ack_excl", HOST_ACK, 0);
      CAL_REQ = 1'b0;
    end
    chk("ack_data", DA_DATA, exp);
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  logic [15:0] model_last;
  logic [15:0] exp_c;
`endif

  initial begin
    RESET_N   = 1'b0;
    CAL_REQ   = 1'b0;
    CAL_DATA  = 16'h0;
    HOST_REQ  = 1'b0;
    HOST_DATA = 16'h0;
    HOST_LOCK = 1'b0;
    clr_mon();
    both_ack = 1'b0;
    tr_prev  = 1'b0;
    tr_len   = 0;
    fall_cyc = 0;
    repeat (3) tick();

    chk("rst_da_data", DA_DATA, 31200);
    chk("rst_last", LAST_CODE, 31200);
    chk("rst_busy", BUSY, 1);
    chk("rst_tr", DA_TR, 0);
    chk("rst_cal_ack", CAL_ACK, 0);
    chk("rst_host_ack", HOST_ACK, 0);
    chk("rst_grant", GRANT_HOST, 0);
    chk("rst_err", TIMEOUT_ERR, 0);

    // Power-up write
    RESET_N = 1'b1;
    clr_mon();
    wait_idle(3000);
    chk("init_tr_count", n_tr, 1);
    chk("init_tr_len", last_len, 2);
    chk("init_last", LAST_CODE, 31200);
    chk("init_da_data", DA_DATA, 31200);
    chk("init_no_ack", n_cal + n_host, 0);

    // Single calibration write
    clr_mon();
    do_req(1'b0, 16'h8000, 16'h8000);
    wait_idle(3000);
    chk("cal_last", LAST_CODE, 16'h8000);
    chk("cal_n_cal", n_cal, 1);
    chk("cal_n_host", n_host, 0);
    chk("cal_grant", GRANT_HOST, 0);

    // Round-robin with both held
    begin
      bit seq[4];
      int k = 0;
      int n = 0;
      clr_mon();
      HOST_DATA = 16'h1111;
      CAL_DATA  = 16'h2222;
      HOST_REQ  = 1'b1;
      CAL_REQ   = 1'b1;
      while (k < 4 && n < 8000) begin
        tick();
        n++;
        if (HOST_ACK || CAL_ACK) begin
          seq[k] = HOST_ACK;
          chk("rr_data", DA_DATA, HOST_ACK ? 16'h1111 : 16'h2222);
          k++;
        end
      end
      HOST_REQ = 1'b0;
      CAL_REQ  = 1'b0;
      chk("rr_count", k, 4);
      chk("rr_g0", seq[0], 1);
      chk("rr_g1", seq[1], 0);
      chk("rr_g2", seq[2], 1);
      chk("rr_g3", seq[3], 0);
      wait_idle(3000);
      chk("rr_tr_count", n_tr, 4);
      chk("rr_tr_len", len_bad, 0);
      chk("rr_settle_gap", gap_bad, 0);
    end

    // Host lock: cal held but ignored
    clr_mon();
    HOST_LOCK = 1'b1;
    CAL_DATA  = 16'h3333;
    CAL_REQ   = 1'b1;
    do_req(1'b1, 16'h7777, 16'h7777);
    wait_idle(3000);
    repeat (50) tick();
    chk("lock_idle", BUSY, 0);
    chk("lock_n_cal", n_cal, 0);
    chk("lock_n_host", n_host, 1);
    chk("lock_grant", GRANT_HOST, 1);
    HOST_LOCK = 1'b0;
    do_req(1'b0, 16'h3333, 16'h3333);
    wait_idle(3000);
    chk("unlock_last", LAST_CODE, 16'h3333);

    // Serializer never goes busy
    clr_mon();
    stuck = 1'b1;
    do_req(1'b1, 16'h4444, 16'h4444);
    repeat (4098) tick();
    chk("to_not_yet", TIMEOUT_ERR, 0);
    tick();
    chk("to_err", TIMEOUT_ERR, 1);
    wait_idle(3000);
    chk("to_err_held", TIMEOUT_ERR, 1);
    chk("to_last", LAST_CODE, 16'h3333);
    chk("to_tr_count", n_tr, 1);
    stuck = 1'b0;
    do_req(1'b0, 16'h5555, 16'h5555);
    wait_idle(3000);
    chk("to_cleared", TIMEOUT_ERR, 0);
    chk("to_recover_last", LAST_CODE, 16'h5555);

    // Reset during a write
    do_req(1'b1, 16'h6666, 16'h6666);
    repeat (5) tick();
    RESET_N = 1'b0;
    tick();
    chk("mrst_da_data", DA_DATA, 31200);
    chk("mrst_last", LAST_CODE, 31200);
    chk("mrst_busy", BUSY, 1);
    chk("mrst_tr", DA_TR, 0);
    chk("mrst_grant", GRANT_HOST, 0);
    RESET_N = 1'b1;
    clr_mon();
    wait_idle(3000);
    chk("mrst_tr_count", n_tr, 1);
    chk("mrst_last_done", LAST_CODE, 31200);

`ifdef DAC_SLEW_LIMIT_EN
    do_req(1'b1, 16'd40000, 16'd33248);
    wait_idle(3000);
    chk("slew_up_last", LAST_CODE, 33248);
    model_last = 16'd33248;
    for (int i = 0; i < 20 && model_last != 16'd1000; i++) begin
      exp_c = (model_last >= 16'd3048) ? model_last - 16'd2048 : 16'd1000;
      do_req(1'b1, 16'd1000, exp_c);
      wait_idle(3000);
      model_last = exp_c;
    end
    chk("slew_walk_last", LAST_CODE, 1000);
    do_req(1'b1, 16'd0, 16'd0);
    wait_idle(3000);
    chk("slew_floor_last", LAST_CODE, 0);
`else
    do_req(1'b1, 16'd40000, 16'd40000);
    wait_idle(3000);
    chk("noslew_last", LAST_CODE, 40000);
`endif

    chk("ack_overlap", both_ack, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: run exceeded 90000 clocks");
    $fatal(1);
  end

endmodule

// File: doc/dac_write_arbiter.md
# dac_write_arbiter

Shares the single DAC8531 serial writer between two requesters: the GPS frequency-calibration loop and a host/manual override port. It sits between those requesters and the DAC serializer, whose handshake is TR/DATA/OVER. It issues a power-up write of a default code, arbitrates pending requests, sequences the serializer handshake, enforces a settle gap between writes, and flags a serializer that never responds.

## Interface
Parameters:
- INIT_CODE, 31200: code written once after reset; reset value of DA_DATA and LAST_CODE.
- TR_CYCLES, 2: DA_TR high time in clocks (min 1).
- SETTLE_CYCLES, 1000: idle gap after each completed write (0 allowed).
- TIMEOUT_CYCLES, 4096: max clocks waiting on DA_OVER in any wait state.
- MAX_STEP, 2048: slew limit per write (only with DAC_SLEW_LIMIT_EN).

Ports:
- CLOCK_10M  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- CAL_REQ  in  1  calibration write request; level, held until CAL_ACK.
- CAL_DATA  in  16  calibration code; stable while CAL_REQ high.
- CAL_ACK  out  1  one-cycle pulse: CAL_DATA latched.
- HOST_REQ  in  1  host write request; level, held until HOST_ACK.
- HOST_DATA  in  16  host code.
- HOST_ACK  out  1  one-cycle pulse: HOST_DATA latched.
- HOST_LOCK  in  1  high: CAL_REQ ignored (never acked), host only.
- DA_TR  out  1  serializer start strobe.
- DA_DATA  out  16  code to serializer; stable from LOAD until next LOAD.
- DA_OVER  in  1  serializer idle (high) / busy (low).
- BUSY  out  1  high in every state except IDLE.
- GRANT_HOST  out  1  owner of current/last write (1 = host).
- LAST_CODE  out  16  last code whose write completed.
- TIMEOUT_ERR  out  1  sticky; cleared by reset or next completed write.

## Operation
- Reset values: CAL_ACK=0, HOST_ACK=0, DA_TR=0, DA_DATA=INIT_CODE, BUSY=1, GRANT_HOST=0, LAST_CODE=INIT_CODE, TIMEOUT_ERR=0, state=LOAD with init flag set.
- States: IDLE, LOAD, WAIT_RDY, STROBE, WAIT_BUSY, WAIT_DONE, SETTLE.
- IDLE: eligible = HOST_REQ, plus CAL_REQ if !HOST_LOCK. One eligible: grant it. Both: grant the one not granted last (round-robin; first tie after reset goes to host). Grant cycle: pulse ACK, latch data into DA_DATA (after slew clamp if enabled), set GRANT_HOST, go WAIT_RDY.
- LOAD (post-reset only): DA_DATA=INIT_CODE, go WAIT_RDY; no ACK.
- WAIT_RDY: on DA_OVER=1 go STROBE.
- STROBE: DA_TR=1 for exactly TR_CYCLES clocks, then WAIT_BUSY.
- WAIT_BUSY: on DA_OVER=0 go WAIT_DONE.
- WAIT_DONE: on DA_OVER=1, LAST_CODE<=DA_DATA, TIMEOUT_ERR<=0, go SETTLE.
- SETTLE: count SETTLE_CYCLES clocks, then IDLE; requests arriving meanwhile stay pending.
- Timeout: a 13+ bit counter clears on entering WAIT_RDY/WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT_CYCLES in any of them: TIMEOUT_ERR<=1, DA_TR<=0, LAST_CODE unchanged, go SETTLE. The write is dropped; the requester was already acked.
- HOST_LOCK rising mid-write: current write completes; only cal eligibility is affected.
- Request dropped before ACK: no grant; no error.
- Reset mid-write: state, counters and outputs return to reset values next clock; init write reissued.

## Timing
- REQ seen high in IDLE -> ACK and DA_DATA update same clock edge (1-cycle latency).
- DA_DATA valid ≥1 clock before DA_TR rises.
- Minimum grant-to-grant spacing: TR_CYCLES + serializer time + SETTLE_CYCLES + 4 clocks.
- No ACK is ever issued outside IDLE; CAL_ACK and HOST_ACK never high together.

## Configuration
- DAC_SLEW_LIMIT_EN defined: granted code is clamped to LAST_CODE ± MAX_STEP, saturating at 0/65535 in 17-bit signed arithmetic. The ACK is still issued; the requester must re-request to move further. Applies to host and cal; not to INIT_CODE.
- Not defined: granted code passed unmodified; MAX_STEP unused.

## Test plan
- Reset, DA_OVER model (busy 20 clocks after TR) -> DA_DATA=31200, one TR of 2 clocks, LAST_CODE=31200, BUSY low after settle.
- CAL_REQ with 0x8000 -> CAL_ACK one pulse, DA_DATA=0x8000, LAST_CODE=0x8000 after done, no HOST_ACK.
- CAL_REQ and HOST_REQ held together for 4 writes -> grants H,C,H,C; SETTLE_CYCLES gap between each pair of TRs.
- HOST_LOCK=1, CAL_REQ held, HOST_REQ pulse -> only host acked; CAL_ACK stays 0 until HOST_LOCK=0.
- DA_OVER stuck high after TR -> TIMEOUT_ERR=1 after 4096 clocks, LAST_CODE unchanged; next good write clears it.
- DAC_SLEW_LIMIT_EN, LAST_CODE=31200, HOST_DATA=40000 -> DA_DATA=33248; HOST_DATA=0 from 1000 -> DA_DATA=0.
